// File: rtl/text_cursor_writer.sv
// ---------------------------------------------------------------------------
// text_cursor_writer
//
// Writer side of the 80x30 character-tile display. Accepts character codes
// over a valid/ready handshake and writes them into the tile RAM at the
// current cursor tile. It also handles CR, LF, BS and FF, wraps lines
// automatically, and clears rows or the whole screen with BLANK writes.
//
// Ports
//   clk         in   system/pixel clock
//   rst_n       in   asynchronous active-low reset
//   char_valid  in   char_data is valid this cycle
//   char_data   in   [7:0] character code
//   char_ready  out  high only in IDLE (combinational from state)
//   wr_en       out  tile RAM write strobe (registered)
//   wr_addr     out  [11:0] tile RAM address, row*COLS + column (registered)
//   wr_data     out  [7:0] tile RAM write data (registered)
//   cursor_x    out  [6:0] cursor column (registered)
//   cursor_y    out  [4:0] cursor row (registered)
//
// State table
//   state         | meaning
//   ST_IDLE       | waiting for and accepting character codes
//   ST_CLR_SCREEN | writing BLANK to tiles 0..COLS*ROWS-1, one per cycle
//   ST_CLR_ROW    | writing BLANK to the COLS tiles of the cursor row
// ---------------------------------------------------------------------------
module text_cursor_writer #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y
);

   localparam logic [11:0] SCREEN_TILES = 12'(COLS * ROWS);
   localparam logic [11:0] ROW_TILES    = 12'(COLS);
   localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);

   localparam logic [7:0] CODE_BS = 8'h08;
   localparam logic [7:0] CODE_LF = 8'h0A;
   localparam logic [7:0] CODE_FF = 8'h0C;
   localparam logic [7:0] CODE_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CLR_SCREEN = 2'd1,
      ST_CLR_ROW    = 2'd2
   } state_t;

   // Row base address as y*64 + y*16, avoiding a multiplier.
   function automatic logic [11:0] row_base(input logic [4:0] y);
      logic [11:0] y_w;
      y_w = {7'd0, y};
      return (y_w << 6) + (y_w << 4);
   endfunction

   state_t      r_state;
   logic [11:0] r_clr_cnt;
   logic [11:0] r_clr_base;
   logic [6:0]  r_x;
   logic [4:0]  r_y;
   logic        r_wr_en;
   logic [11:0] r_wr_addr;
   logic [7:0]  r_wr_data;

   state_t      w_state_nxt;
   logic [11:0] w_clr_cnt_nxt;
   logic [11:0] w_clr_base_nxt;
   logic [6:0]  w_x_nxt;
   logic [4:0]  w_y_nxt;
   logic        w_wr_en_nxt;
   logic [11:0] w_wr_addr_nxt;
   logic [7:0]  w_wr_data_nxt;

   logic [4:0]  w_next_row;
   logic [11:0] w_cur_addr;
   logic [11:0] w_next_row_base;
   logic        w_printable;
   logic        w_accept;

   assign w_next_row      = (r_y == LAST_ROW) ? 5'd0 : r_y + 5'd1;
   assign w_cur_addr      = row_base(r_y) + {5'd0, r_x};
   assign w_next_row_base = row_base(w_next_row);
   assign w_printable     = (char_data >= 8'h20) && (char_data <= 8'h7E);
   assign w_accept        = char_valid && (r_state == ST_IDLE);

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_cnt_nxt  = r_clr_cnt;
      w_clr_base_nxt = r_clr_base;
      w_x_nxt        = r_x;
      w_y_nxt        = r_y;
      w_wr_en_nxt    = 1'b0;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_printable) begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = w_cur_addr;
                  w_wr_data_nxt = char_data;
                  if (r_x == LAST_COL) begin
                     // Character lands now; the new row's clear starts
                     // on the following cycle with counter at 0.
                     w_x_nxt        = 7'd0;
                     w_y_nxt        = w_next_row;
                     w_clr_base_nxt = w_next_row_base;
                     w_clr_cnt_nxt  = 12'd0;
                     w_state_nxt    = ST_CLR_ROW;
                  end else begin
                     w_x_nxt = r_x + 7'd1;
                  end
               end else if (char_data == CODE_CR) begin
                  w_x_nxt = 7'd0;
               end else if (char_data == CODE_LF) begin
                  // First clear write is issued at the acceptance edge.
                  w_x_nxt        = 7'd0;
                  w_y_nxt        = w_next_row;
                  w_clr_base_nxt = w_next_row_base;
                  w_wr_en_nxt    = 1'b1;
                  w_wr_addr_nxt  = w_next_row_base;
                  w_wr_data_nxt  = BLANK;
                  w_clr_cnt_nxt  = 12'd1;
                  w_state_nxt    = ST_CLR_ROW;
               end else if (char_data == CODE_BS) begin
                  if (r_x != 7'd0) begin
                     w_x_nxt       = r_x - 7'd1;
                     w_wr_en_nxt   = 1'b1;
                     w_wr_addr_nxt = w_cur_addr - 12'd1;
                     w_wr_data_nxt = BLANK;
                  end
               end else if (char_data == CODE_FF) begin
                  w_x_nxt       = 7'd0;
                  w_y_nxt       = 5'd0;
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = 12'd0;
                  w_wr_data_nxt = BLANK;
                  w_clr_cnt_nxt = 12'd1;
                  w_state_nxt   = ST_CLR_SCREEN;
               end
            end
         end

         ST_CLR_SCREEN: begin
            if (r_clr_cnt == SCREEN_TILES) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_clr_cnt;
               w_wr_data_nxt = BLANK;
               w_clr_cnt_nxt = r_clr_cnt + 12'd1;
            end
         end

         ST_CLR_ROW: begin
            if (r_clr_cnt == ROW_TILES) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_clr_base + r_clr_cnt;
               w_wr_data_nxt = BLANK;
               w_clr_cnt_nxt = r_clr_cnt + 12'd1;
            end
         end

         default: begin
            w_state_nxt   = ST_CLR_SCREEN;
            w_clr_cnt_nxt = 12'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_CLR_SCREEN;
         r_clr_cnt  <= 12'd0;
         r_clr_base <= 12'd0;
         r_x        <= 7'd0;
         r_y        <= 5'd0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 12'd0;
         r_wr_data  <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_cnt  <= w_clr_cnt_nxt;
         r_clr_base <= w_clr_base_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_wr_en    <= w_wr_en_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
      end
   end

   assign char_ready = (r_state == ST_IDLE);
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign cursor_x   = r_x;
   assign cursor_y   = r_y;

endmodule

// File: tb/tb_text_cursor_writer.sv
module tb_text_cursor_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'd0;
   logic        char_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;

   text_cursor_writer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int c;
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  mx = 0;
   int  my = 0;
   int  busy_until = 1 << 30;
   int  last_accept = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic push_wr(input int c, input int a, input int d);
      wr_t e;
      e.c = c;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Reference model: screen semantics in tile coordinates.
   task automatic model_accept(input int code, input int n);
      if (code >= 32 && code <= 126) begin
         push_wr(n + 1, my * 80 + mx, code);
         if (mx == 79) begin
            mx = 0;
            my = (my + 1) % 30;
            for (int i = 0; i < 80; i++) push_wr(n + 2 + i, my * 80 + i, 32);
            busy_until = n + 81;
         end else begin
            mx++;
         end
      end else if (code == 13) begin
         mx = 0;
      end else if (code == 10) begin
         mx = 0;
         my = (my + 1) % 30;
         for (int i = 0; i < 80; i++) push_wr(n + 1 + i, my * 80 + i, 32);
         busy_until = n + 80;
      end else if (code == 8) begin
         if (mx > 0) begin
            mx--;
            push_wr(n + 1, my * 80 + mx, 32);
         end
      end else if (code == 12) begin
         mx = 0;
         my = 0;
         for (int i = 0; i < 2400; i++) push_wr(n + 1 + i, i, 32);
         busy_until = n + 2400;
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_wr_en", int'(wr_en), 0);
         check("rst_cursor", int'({cursor_y, cursor_x}), 0);
         check("rst_ready", int'(char_ready), 0);
      end else begin
         check("cursor_x", int'(cursor_x), mx);
         check("cursor_y", int'(cursor_y), my);
         check("char_ready", int'(char_ready), (cyc > busy_until) ? 1 : 0);
         if (wr_en) begin
            if (exp_q.size() == 0) begin
               $display("FAIL spurious_write: addr %0d data %0d with nothing expected (cycle %0d)",
                        wr_addr, wr_data, cyc);
               total++;
               bad++;
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("write_cycle", cyc, e.c);
               check("write_addr", int'(wr_addr), e.addr);
               check("write_data", int'(wr_data), e.data);
            end
         end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
            wr_t e;
            e = exp_q.pop_front();
            $display("FAIL missing_write: got no write, expected addr %0d data %0d at cycle %0d",
                     e.addr, e.data, e.c);
            total++;
            bad++;
         end
      end
   end

   task automatic release_reset();
      int rel;
      rst_n = 1'b1;
      rel = cyc;
      mx = 0;
      my = 0;
      busy_until = rel + 2400;
      for (int i = 0; i < 2400; i++) push_wr(rel + 1 + i, i, 32);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      exp_q.delete();
      busy_until = 1 << 30;
      mx = 0;
      my = 0;
   endtask

   task automatic wait_accept(input int code);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 5000 && !got; n++) begin
         @(negedge clk);
         #1;
         if (char_ready && char_valid) begin
            got = 1'b1;
            last_accept = cyc;
            model_accept(code, cyc);
         end
      end
      if (!got) fail_now("accept_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int code);
      char_valid = 1'b1;
      char_data  = 8'(code);
      wait_accept(code);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 5000 && !done; n++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && cyc > busy_until) done = 1'b1;
      end
      if (!done) fail_now("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   function automatic int rand_code();
      int r;
      r = int'($urandom_range(0, 63));
      if (r == 0) return 12;
      if (r < 6) return 10;
      if (r < 10) return 13;
      if (r < 16) return 8;
      if (r < 18) return int'($urandom_range(128, 255));
      if (r < 19) return int'($urandom_range(0, 7));
      return int'($urandom_range(32, 126));
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int rel;

      // Power-up clear
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      release_reset();
      wait_idle();
      check("post_clear_x", int'(cursor_x), 0);
      check("post_clear_y", int'(cursor_y), 0);

      // "AB" back to back
      send_byte(8'h41);
      a = last_accept;
      send_byte(8'h42);
      check("ab_back_to_back", last_accept, a + 1);
      char_valid = 1'b0;
      wait_idle();
      check("ab_cursor_x", int'(cursor_x), 2);
      check("ab_cursor_y", int'(cursor_y), 0);

      // Home, then a full line forcing a wrap
      send_byte(8'h0C);
      for (int i = 0; i < 80; i++) send_byte(int'($urandom_range(32, 126)));
      char_valid = 1'b0;
      check("wrap_cursor_x", int'(cursor_x), 0);
      check("wrap_cursor_y", int'(cursor_y), 1);
      check("wrap_ready_low", int'(char_ready), 0);
      wait_idle();

      // Move to (5,29), then LF wraps to row 0
      for (int i = 0; i < 28; i++) send_byte(8'h0A);
      for (int i = 0; i < 5; i++) send_byte(int'($urandom_range(32, 126)));
      char_valid = 1'b0;
      wait_idle();
      check("r29_cursor_x", int'(cursor_x), 5);
      check("r29_cursor_y", int'(cursor_y), 29);
      send_byte(8'h0A);
      char_valid = 1'b0;
      check("lf29_cursor_x", int'(cursor_x), 0);
      check("lf29_cursor_y", int'(cursor_y), 0);
      wait_idle();

      // Backspace at (3,2) and at column 0
      send_byte(8'h0A);
      send_byte(8'h0A);
      for (int i = 0; i < 3; i++) send_byte(int'($urandom_range(32, 126)));
      send_byte(8'h08);
      char_valid = 1'b0;
      check("bs_cursor_x", int'(cursor_x), 2);
      check("bs_cursor_y", int'(cursor_y), 2);
      send_byte(8'h08);
      send_byte(8'h08);
      send_byte(8'h08);
      char_valid = 1'b0;
      wait_idle();
      check("bs0_cursor_x", int'(cursor_x), 0);
      check("bs0_cursor_y", int'(cursor_y), 2);

      // CR at (40,7)
      send_byte(8'h0C);
      for (int i = 0; i < 7; i++) send_byte(8'h0A);
      for (int i = 0; i < 40; i++) send_byte(int'($urandom_range(32, 126)));
      send_byte(8'h0D);
      char_valid = 1'b0;
      wait_idle();
      check("cr_cursor_x", int'(cursor_x), 0);
      check("cr_cursor_y", int'(cursor_y), 7);

      // Randomized stream with idle gaps
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            char_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         send_byte(rand_code());
      end
      char_valid = 1'b0;
      wait_idle();

      // Reset in the middle of a screen clear, with a code held pending
      send_byte(8'h0C);
      char_valid = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      char_valid = 1'b1;
      char_data  = 8'h51;
      repeat (5) @(posedge clk);
      #1;
      assert_reset();
      #1;
      check("abort_wr_en", int'(wr_en), 0);
      check("abort_cursor", int'({cursor_y, cursor_x}), 0);
      repeat (3) @(posedge clk);
      #1;
      release_reset();
      rel = cyc;
      wait_accept(8'h51);
      check("held_accept_cycle", last_accept, rel + 2401);
      char_valid = 1'b0;
      wait_idle();
      check("final_cursor_x", int'(cursor_x), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
